flappy_game_ctrl: RTL and testbench
===================================

# flappy_game_ctrl

Top-level game sequencer for the Flappy Bird design. It runs the game state machine (idle, play, dying, over) and turns each video frame tick into an ordered sequence of one-cycle strobes: bird physics, pipe scroll, then a collision-check request/response. It also latches flap presses between frames and keeps the current and high score. It sits between the VGA timing block, which supplies `Frame_Tick`, and the bird, pipe and collision datapaths, which it steps.

## Interface
- `SCORE_W`, 8: score counter width.
- `DYING_FRAMES`, 32: frames spent in DYING before OVER; range 1..255.
- `COL_TIMEOUT`, 15: cycles to wait for `Col_Valid` before giving up; range 1..255.

- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  level; starts a game from IDLE or OVER.
- `Ack`  in  1  level; returns from OVER to IDLE.
- `Flap_Button`  in  1  synchronized button level.
- `Frame_Tick`  in  1  one-cycle pulse per frame.
- `Col_Valid`  in  1  collision result valid, one-cycle pulse.
- `Collide`  in  1  collision result; sampled only when `Col_Valid` is high.
- `Pipe_Passed`  in  1  one-cycle pulse when the bird clears a pipe.
- `Pause`  in  1  pause button level; this port exists only with `FLAPPY_PAUSE_EN`.
- `Game_Init`  out  1  one-cycle strobe telling the datapaths to reload start positions.
- `Bird_Step`, `Pipe_Step`, `Col_Req`  out  1 each  one-cycle sequencing strobes.
- `Bird_Flap`  out  1  qualifies `Bird_Step`: apply a flap impulse this step.
- `Score`, `High_Score`  out  `SCORE_W` each.
- `Frame_Overrun`  out  1  sticky error flag.
- `q_Idle`, `q_Play`, `q_Dying`, `q_Over`  out  1 each  one-hot state.
- `q_Paused`  out  1  exists only with `FLAPPY_PAUSE_EN`.

## Operation
**Reset values**
- State is IDLE.
- All strobes are 0.
- `Score`, `High_Score` and `Frame_Overrun` are 0.
- The flap latch is clear.

**Game states**
- IDLE:
  - `Start` → PLAY.
  - `Score` cleared to 0.
  - `Game_Init` pulsed for one cycle.
- PLAY: runs the frame sequence below.
  - Collision reported → DYING.
- DYING:
  - Each frame tick issues `Bird_Step` only: no `Pipe_Step`, no `Bird_Flap`, no `Col_Req`.
  - After `DYING_FRAMES` ticks → OVER.
  - On the OVER transition, `High_Score` takes `Score` if `Score` > `High_Score`.
- OVER:
  - `Ack` → IDLE.
  - `Start` alone → PLAY, with `Score` cleared and `Game_Init` pulsed.
  - `Ack` and `Start` together → IDLE.

**Frame sequence (PLAY), phases in order**
- WAIT: `Frame_Tick` → BIRD.
- BIRD: `Bird_Step` = 1; `Bird_Flap` = flap latch; flap latch cleared.
- PIPE: `Pipe_Step` = 1.
- REQ: `Col_Req` = 1.
- CWAIT:
  - `Col_Valid` with `Collide` = 1 → DYING.
  - `Col_Valid` with `Collide` = 0 → WAIT.
  - `COL_TIMEOUT` cycles with no `Col_Valid` → WAIT; sets `Frame_Overrun`; counts as no collision.

**Flap latch**
- Set on a rising edge of `Flap_Button`, in PLAY only.
- Multiple edges within one frame produce a single flap.
- An edge in the same cycle as BIRD is kept for the next frame.

**Score**
- Incremented by `Pipe_Passed`, in PLAY only.
- Saturates at all-ones.
- `Pipe_Passed` outside PLAY is ignored.

**Overrun and reset**
- `Frame_Tick` while PLAY is not in WAIT: tick dropped; `Frame_Overrun` set.
- `Frame_Overrun` is cleared only by `Reset`.
- `High_Score` is cleared only by `Reset`.
- `Reset` mid-sequence: all strobes drop immediately, asynchronously.

## Timing
- Tick sampled high at cycle N gives: `Bird_Step` at N+1, `Pipe_Step` at N+2, `Col_Req` at N+3.
- `Col_Valid` is accepted from N+4 onward.
- Fastest frame: 5 cycles.
- All outputs are registered. At most one strobe of `Game_Init`/`Bird_Step`/`Pipe_Step`/`Col_Req` is high in any cycle.
- `Game_Init` is high in the first cycle of PLAY. The first `Bird_Step` comes on the first tick after that.
- In DYING, `Bird_Step` is at N+1 after each tick.

## Configuration
- Macro: `FLAPPY_PAUSE_EN`.
- Defined:
  - A rising edge on `Pause` in PLAY toggles a paused flag, shown on `q_Paused`.
  - The toggle takes effect only in phase WAIT; an edge seen earlier is held until WAIT.
  - While paused: ticks are ignored (no overrun), flap edges are ignored, `Pipe_Passed` is ignored.
  - Leaving PLAY clears the paused flag.
- Undefined: the `Pause` and `q_Paused` ports are absent, and the block never pauses.

## Test plan
- Reset, `Start`, then ticks with `Col_Valid` = 1, `Collide` = 0 at N+4 → `Game_Init` once; strobes at N+1/N+2/N+3; stays PLAY.
- Three `Flap_Button` edges within one frame → exactly one `Bird_Flap` = 1, at the next `Bird_Step`; the following frame has `Bird_Flap` = 0.
- 300 `Pipe_Passed` pulses with `SCORE_W` = 8 → `Score` = 255; then `Collide` = 1 → DYING; after 32 ticks → OVER with `High_Score` = 255.
- `Frame_Tick` at REQ, and separately no `Col_Valid` for 15 cycles → `Frame_Overrun` = 1, the tick is dropped, the sequence returns to WAIT.
- In OVER, `Start` and `Ack` high together → IDLE. Then `Start` → `Score` = 0, `High_Score` retained.
- `Reset` asserted during PIPE → all outputs at reset values in the same cycle, state is IDLE.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game sequencer for Flappy Bird. Runs the IDLE/PLAY/DYING/OVER state machine
// and turns each frame tick into ordered one-cycle strobes: bird step, pipe
// step, collision request. It then waits for the collision response. It also
// latches flap presses between frames and keeps the current and high score.
//
// Optional feature macro: FLAPPY_PAUSE_EN adds the Pause input and q_Paused output.
//
// Ports
//   Clk, Reset          clock, async active-high reset
//   Start, Ack          game control levels
//   Flap_Button         synchronized flap button level
//   Frame_Tick          one-cycle pulse per video frame
//   Col_Valid, Collide  collision response (Collide valid with Col_Valid)
//   Pipe_Passed         one-cycle pulse when a pipe is cleared
//   Pause               (FLAPPY_PAUSE_EN only) pause button level
//   Game_Init           reload-start-positions strobe
//   Bird_Step, Bird_Flap, Pipe_Step, Col_Req  sequencing strobes
//   Score, High_Score   scores
//   Frame_Overrun       sticky error flag
//   q_Idle..q_Over      one-hot state; q_Paused (FLAPPY_PAUSE_EN only)
module flappy_game_ctrl #(
    parameter int SCORE_W      = 8,
    parameter int DYING_FRAMES = 32,
    parameter int COL_TIMEOUT  = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               Flap_Button,
    input  logic               Frame_Tick,
    input  logic               Col_Valid,
    input  logic               Collide,
    input  logic               Pipe_Passed,
`ifdef FLAPPY_PAUSE_EN
    input  logic               Pause,
    output logic               q_Paused,
`endif
    output logic               Game_Init,
    output logic               Bird_Step,
    output logic               Bird_Flap,
    output logic               Pipe_Step,
    output logic               Col_Req,
    output logic [SCORE_W-1:0] Score,
    output logic [SCORE_W-1:0] High_Score,
    output logic               Frame_Overrun,
    output logic               q_Idle,
    output logic               q_Play,
    output logic               q_Dying,
    output logic               q_Over
);

    // One-hot encoding so the q_* outputs come straight from flops.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_PLAY  = 4'b0010,
        S_DYING = 4'b0100,
        S_OVER  = 4'b1000
    } state_t;

    typedef enum logic [2:0] {P_WAIT, P_BIRD, P_PIPE, P_REQ, P_CWAIT} phase_t;

    localparam logic [7:0] COL_LAST = 8'(COL_TIMEOUT - 1);
    localparam logic [7:0] DY_LAST  = 8'(DYING_FRAMES - 1);

    state_t             state, state_d;
    phase_t             phase, phase_d;
    logic [7:0]         tcnt, tcnt_d, dcnt, dcnt_d;
    logic               flap_prev, flap_latch, latch_d;
    logic [SCORE_W-1:0] score, score_d, high_score, hs_d;
    logic               overrun, ovr_d;
    logic               init_q, bird_q, flap_q, pipe_q, req_q;
    logic               init_d, bird_d, flap_d, pipe_d, req_d;
    logic               flap_edge;
    logic               paused;

`ifdef FLAPPY_PAUSE_EN
    logic pause_prev, pause_pend, pend_d, paused_d, pause_edge;
    assign pause_edge = Pause & ~pause_prev;
    assign q_Paused   = paused;
`else
    assign paused = 1'b0;
`endif

    assign flap_edge = Flap_Button & ~flap_prev;

    always_comb begin
        state_d = state;
        phase_d = phase;
        tcnt_d  = tcnt;
        dcnt_d  = dcnt;
        latch_d = flap_latch;
        score_d = score;
        hs_d    = high_score;
        ovr_d   = overrun;
        init_d  = 1'b0;
        bird_d  = 1'b0;
        flap_d  = 1'b0;
        pipe_d  = 1'b0;
        req_d   = 1'b0;
`ifdef FLAPPY_PAUSE_EN
        pend_d   = pause_pend;
        paused_d = paused;
`endif
        case (state)
            S_IDLE: if (Start) begin
                state_d = S_PLAY;
                phase_d = P_WAIT;
                init_d  = 1'b1;
                score_d = '0;
                latch_d = 1'b0;
            end
            S_PLAY: begin
                if (flap_edge && !paused) latch_d = 1'b1;
                if (Pipe_Passed && !paused && score != '1) score_d = score + 1'b1;
                // A tick outside WAIT is dropped; paused implies WAIT.
                if (Frame_Tick && phase != P_WAIT) ovr_d = 1'b1;
                case (phase)
                    P_WAIT: if (Frame_Tick && !paused) begin
                        phase_d = P_BIRD;
                        bird_d  = 1'b1;
                        // An edge in the tick cycle still counts for this frame;
                        // one during BIRD re-sets the latch for the next frame.
                        flap_d  = flap_latch | (flap_edge & ~paused);
                        latch_d = 1'b0;
                    end
                    P_BIRD: begin phase_d = P_PIPE; pipe_d = 1'b1; end
                    P_PIPE: begin phase_d = P_REQ;  req_d  = 1'b1; end
                    P_REQ:  begin phase_d = P_CWAIT; tcnt_d = '0; end
                    P_CWAIT: begin
                        if (Col_Valid) begin
                            phase_d = P_WAIT;
                            if (Collide) begin state_d = S_DYING; dcnt_d = '0; end
                        end else if (tcnt == COL_LAST) begin
                            // Give up: treat as no collision.
                            phase_d = P_WAIT;
                            ovr_d   = 1'b1;
                        end else begin
                            tcnt_d = tcnt + 8'd1;
                        end
                    end
                    default: phase_d = P_WAIT;
                endcase
`ifdef FLAPPY_PAUSE_EN
                if (pause_edge) pend_d = 1'b1;
                if (phase == P_WAIT && (pause_pend || pause_edge)) begin
                    paused_d = ~paused;
                    pend_d   = 1'b0;
                end
`endif
            end
            S_DYING: if (Frame_Tick) begin
                bird_d = 1'b1;
                if (dcnt == DY_LAST) begin
                    state_d = S_OVER;
                    if (score > high_score) hs_d = score;
                end else begin
                    dcnt_d = dcnt + 8'd1;
                end
            end
            S_OVER: if (Ack) begin
                state_d = S_IDLE;
                score_d = '0;
            end else if (Start) begin
                state_d = S_PLAY;
                phase_d = P_WAIT;
                init_d  = 1'b1;
                score_d = '0;
                latch_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FLAPPY_PAUSE_EN
        if (state_d != S_PLAY) begin
            paused_d = 1'b0;
            pend_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            phase      <= P_WAIT;
            tcnt       <= '0;
            dcnt       <= '0;
            flap_prev  <= 1'b0;
            flap_latch <= 1'b0;
            score      <= '0;
            high_score <= '0;
            overrun    <= 1'b0;
            init_q     <= 1'b0;
            bird_q     <= 1'b0;
            flap_q     <= 1'b0;
            pipe_q     <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            tcnt       <= tcnt_d;
            dcnt       <= dcnt_d;
            flap_prev  <= Flap_Button;
            flap_latch <= latch_d;
            score      <= score_d;
            high_score <= hs_d;
            overrun    <= ovr_d;
            init_q     <= init_d;
            bird_q     <= bird_d;
            flap_q     <= flap_d;
            pipe_q     <= pipe_d;
            req_q      <= req_d;
        end
    end

`ifdef FLAPPY_PAUSE_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pause_prev <= 1'b0;
            pause_pend <= 1'b0;
            paused     <= 1'b0;
        end else begin
            pause_prev <= Pause;
            pause_pend <= pend_d;
            paused     <= paused_d;
        end
    end
`endif

    assign Game_Init     = init_q;
    assign Bird_Step     = bird_q;
    assign Bird_Flap     = flap_q;
    assign Pipe_Step     = pipe_q;
    assign Col_Req       = req_q;
    assign Score         = score;
    assign High_Score    = high_score;
    assign Frame_Overrun = overrun;
    assign q_Idle        = state[0];
    assign q_Play        = state[1];
    assign q_Dying       = state[2];
    assign q_Over        = state[3];

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: a frame-timeline model checked every
// cycle, plus hand-computed literal checks at the points of interest.
module tb_flappy_game_ctrl;

    localparam int SCORE_W      = 8;
    localparam int DYING_FRAMES = 32;
    localparam int COL_TIMEOUT  = 15;
    localparam int SMAX         = (1 << SCORE_W) - 1;

    logic Clk = 1'b0, Reset = 1'b1;
    logic Start = 0, Ack = 0, Flap_Button = 0, Frame_Tick = 0;
    logic Col_Valid = 0, Collide = 0, Pipe_Passed = 0;
    logic Game_Init, Bird_Step, Bird_Flap, Pipe_Step, Col_Req;
    logic [SCORE_W-1:0] Score, High_Score;
    logic Frame_Overrun, q_Idle, q_Play, q_Dying, q_Over;
`ifdef FLAPPY_PAUSE_EN
    logic Pause = 1'b0;
    logic q_Paused;
`endif

    int n_chk = 0, n_err = 0;

    flappy_game_ctrl #(.SCORE_W(SCORE_W), .DYING_FRAMES(DYING_FRAMES),
                       .COL_TIMEOUT(COL_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .Flap_Button(Flap_Button), .Frame_Tick(Frame_Tick),
        .Col_Valid(Col_Valid), .Collide(Collide), .Pipe_Passed(Pipe_Passed),
`ifdef FLAPPY_PAUSE_EN
        .Pause(Pause), .q_Paused(q_Paused),
`endif
        .Game_Init(Game_Init), .Bird_Step(Bird_Step), .Bird_Flap(Bird_Flap),
        .Pipe_Step(Pipe_Step), .Col_Req(Col_Req), .Score(Score),
        .High_Score(High_Score), .Frame_Overrun(Frame_Overrun),
        .q_Idle(q_Idle), .q_Play(q_Play), .q_Dying(q_Dying), .q_Over(q_Over)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---- model: frame timeline measured in cycles since the accepted tick ----
    int  cyc = 0, m_mode = 0, m_fs = 0, m_dt = 0, m_score = 0, m_hs = 0;
    bit  m_busy = 0, m_ovr = 0, m_flap = 0, m_fprev = 0;
    bit  e_init = 0, e_bird = 0, e_flap = 0, e_pipe = 0, e_req = 0;

    always @(posedge Clk or posedge Reset) begin
        int  age;
        bit  fedge;
        if (Reset) begin
            m_mode = 0; m_score = 0; m_hs = 0; m_busy = 0; m_ovr = 0;
            m_flap = 0; m_fprev = 0; m_dt = 0;
            e_init = 0; e_bird = 0; e_flap = 0; e_pipe = 0; e_req = 0;
        end else begin
            cyc++;
            e_init = 0; e_bird = 0; e_flap = 0; e_pipe = 0; e_req = 0;
            fedge = Flap_Button && !m_fprev;
            m_fprev = Flap_Button;
            case (m_mode)
                0: if (Start) begin
                    m_mode = 1; e_init = 1; m_score = 0; m_flap = 0; m_busy = 0;
                end
                1: begin
                    if (Pipe_Passed && m_score < SMAX) m_score++;
                    if (!m_busy) begin
                        if (Frame_Tick) begin
                            m_busy = 1; m_fs = cyc; e_bird = 1;
                            e_flap = m_flap | fedge; m_flap = 0;
                        end else if (fedge) m_flap = 1;
                    end else begin
                        age = cyc - m_fs;
                        if (fedge) m_flap = 1;
                        if (Frame_Tick) m_ovr = 1;
                        if (age == 1) e_pipe = 1;
                        if (age == 2) e_req = 1;
                        if (age >= 4) begin
                            if (Col_Valid) begin
                                m_busy = 0;
                                if (Collide) begin m_mode = 2; m_dt = 0; end
                            end else if (age == 3 + COL_TIMEOUT) begin
                                m_busy = 0; m_ovr = 1;
                            end
                        end
                    end
                end
                2: if (Frame_Tick) begin
                    e_bird = 1; m_dt++;
                    if (m_dt == DYING_FRAMES) begin
                        m_mode = 3;
                        if (m_score > m_hs) m_hs = m_score;
                    end
                end
                default: if (Ack) begin
                    m_mode = 0; m_score = 0;
                end else if (Start) begin
                    m_mode = 1; e_init = 1; m_score = 0; m_flap = 0; m_busy = 0;
                end
            endcase
        end
    end

    always @(negedge Clk) if (!Reset) begin
        chk("m_game_init", Game_Init, e_init);
        chk("m_bird_step", Bird_Step, e_bird);
        chk("m_bird_flap", Bird_Flap, e_flap);
        chk("m_pipe_step", Pipe_Step, e_pipe);
        chk("m_col_req",   Col_Req,   e_req);
        chk("m_score",     Score,      m_score);
        chk("m_high",      High_Score, m_hs);
        chk("m_overrun",   Frame_Overrun, m_ovr);
        chk("m_state", {q_Over, q_Dying, q_Play, q_Idle},
            {m_mode == 3, m_mode == 2, m_mode == 1, m_mode == 0});
    end

    // ---- stimulus ----
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One full frame; Col_Valid returned at N+4. Optionally press flap during BIRD.
    task automatic frame(input bit col, input bit flap_bird, input int exp_flap);
        Frame_Tick = 1; step(1); Frame_Tick = 0;
        if (flap_bird) Flap_Button = 1;
        chk("bird_step_n1", Bird_Step, 1);
        if (exp_flap >= 0) chk("bird_flap", Bird_Flap, exp_flap == 1);
        step(1); Flap_Button = 0;
        chk("pipe_step_n2", Pipe_Step, 1);
        step(1);
        chk("col_req_n3", Col_Req, 1);
        step(1); Col_Valid = 1; Collide = col;
        step(1); Col_Valid = 0; Collide = 0;
    endtask

    task automatic dying_tick();
        Frame_Tick = 1; step(1); Frame_Tick = 0;
        chk("dying_bird", Bird_Step, 1);
        chk("dying_pipe", Pipe_Step, 0);
        step(2);
    endtask

    task automatic do_reset();
        Reset = 1; step(2); Reset = 0; step(1);
    endtask

    task automatic start_game();
        Start = 1; step(1); Start = 0;
        chk("game_init", Game_Init, 1);
        chk("q_play", q_Play, 1);
        chk("score_clr", Score, 0);
        step(1);
        chk("game_init_once", Game_Init, 0);
    endtask

    initial begin
        step(3);
        chk("rst_idle", q_Idle, 1);
        chk("rst_score", Score, 0);
        chk("rst_ovr", Frame_Overrun, 0);
        chk("rst_strobes", {Game_Init, Bird_Step, Pipe_Step, Col_Req, Bird_Flap}, 0);
        Reset = 0; step(2);

        // Basic frames
        start_game();
        step(2);
        frame(0, 0, 0);
        frame(0, 0, 0);
        chk("still_play", q_Play, 1);

        // Three flap edges -> one flap, then none; edge during BIRD kept
        for (int i = 0; i < 3; i++) begin
            Flap_Button = 1; step(1); Flap_Button = 0; step(1);
        end
        frame(0, 1, 1);
        frame(0, 0, 1);
        frame(0, 0, 0);

        // Tick during REQ is dropped and flags overrun
        chk("ovr_before", Frame_Overrun, 0);
        Frame_Tick = 1; step(1); Frame_Tick = 0;
        step(2); Frame_Tick = 1;
        step(1); Frame_Tick = 0;
        chk("ovr_req", Frame_Overrun, 1);
        chk("tick_dropped", Bird_Step, 0);
        Col_Valid = 1; step(1); Col_Valid = 0;
        frame(0, 0, 0);

        // Collision timeout
        do_reset();
        start_game();
        Frame_Tick = 1; step(1); Frame_Tick = 0;
        step(3 + COL_TIMEOUT - 1);
        chk("ovr_not_yet", Frame_Overrun, 0);
        step(1);
        chk("ovr_timeout", Frame_Overrun, 1);
        chk("timeout_play", q_Play, 1);
        frame(0, 0, 0);

        // Score saturation, collision, dying, over
        for (int i = 0; i < 300; i++) begin
            Pipe_Passed = 1; step(1); Pipe_Passed = 0; step(1);
        end
        chk("score_sat", Score, 255);
        frame(1, 0, -1);
        chk("q_dying", q_Dying, 1);
        for (int i = 0; i < DYING_FRAMES - 1; i++) dying_tick();
        chk("dying_31", q_Dying, 1);
        dying_tick();
        chk("q_over", q_Over, 1);
        chk("high_255", High_Score, 255);

        // Start+Ack together -> IDLE; then Start keeps High_Score
        Start = 1; Ack = 1; step(1); Start = 0; Ack = 0;
        chk("ack_start_idle", q_Idle, 1);
        Pipe_Passed = 1; step(1); Pipe_Passed = 0;
        chk("idle_pp_ignored", Score, 0);
        start_game();
        chk("high_kept", High_Score, 255);

        // Short game with score 3; Pipe_Passed in DYING/OVER ignored
        for (int i = 0; i < 3; i++) begin
            Pipe_Passed = 1; step(1); Pipe_Passed = 0; step(1);
        end
        frame(1, 0, 0);
        Pipe_Passed = 1; step(1); Pipe_Passed = 0;
        for (int i = 0; i < DYING_FRAMES; i++) dying_tick();
        Pipe_Passed = 1; step(1); Pipe_Passed = 0;
        chk("score_3", Score, 3);
        chk("high_still_255", High_Score, 255);

        // Start alone from OVER
        start_game();
        frame(0, 0, 0);

        // Reset during PIPE: outputs drop at once
        Frame_Tick = 1; step(1); Frame_Tick = 0;
        step(1);
        chk("in_pipe", Pipe_Step, 1);
        #2 Reset = 1;
        #1;
        chk("async_pipe", Pipe_Step, 0);
        chk("async_idle", {q_Over, q_Dying, q_Play, q_Idle}, 4'b0001);
        chk("async_high", High_Score, 0);
        step(2); Reset = 0; step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
